// File: rtl/ex_pkg.sv
// Shared constants for the RV32IM execute stage: bus widths, result classes,
// ALU operation codes, stall encodings and the divider state type.
package ex_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;

  localparam logic                  RstEnable  = 1'b1;
  localparam logic                  Stop       = 1'b1;
  localparam logic                  NoStop     = 1'b0;
  localparam logic [RegBus-1:0]     ZeroWord   = 32'h0000_0000;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = 5'b00000;

  // Result class selected by the decoder
  localparam logic [AluSelBus-1:0] EXE_RES_NOP         = 3'd0;
  localparam logic [AluSelBus-1:0] EXE_RES_LOGIC       = 3'd1;
  localparam logic [AluSelBus-1:0] EXE_RES_SHIFT       = 3'd2;
  localparam logic [AluSelBus-1:0] EXE_RES_ARITH       = 3'd3;
  localparam logic [AluSelBus-1:0] EXE_RES_JUMP_BRANCH = 3'd4;
  localparam logic [AluSelBus-1:0] EXE_RES_MUL         = 3'd5;
  localparam logic [AluSelBus-1:0] EXE_RES_DIV         = 3'd6;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP    = 8'h00;
  localparam logic [AluOpBus-1:0] EXE_AND_OP    = 8'h01;
  localparam logic [AluOpBus-1:0] EXE_OR_OP     = 8'h02;
  localparam logic [AluOpBus-1:0] EXE_XOR_OP    = 8'h03;
  localparam logic [AluOpBus-1:0] EXE_SLL_OP    = 8'h04;
  localparam logic [AluOpBus-1:0] EXE_SRL_OP    = 8'h05;
  localparam logic [AluOpBus-1:0] EXE_SRA_OP    = 8'h06;
  localparam logic [AluOpBus-1:0] EXE_ADD_OP    = 8'h07;
  localparam logic [AluOpBus-1:0] EXE_SUB_OP    = 8'h08;
  localparam logic [AluOpBus-1:0] EXE_SLT_OP    = 8'h09;
  localparam logic [AluOpBus-1:0] EXE_SLTU_OP   = 8'h0A;
  localparam logic [AluOpBus-1:0] EXE_MUL_OP    = 8'h0B;
  localparam logic [AluOpBus-1:0] EXE_MULH_OP   = 8'h0C;
  localparam logic [AluOpBus-1:0] EXE_MULHSU_OP = 8'h0D;
  localparam logic [AluOpBus-1:0] EXE_MULHU_OP  = 8'h0E;
  localparam logic [AluOpBus-1:0] EXE_DIV_OP    = 8'h0F;
  localparam logic [AluOpBus-1:0] EXE_DIVU_OP   = 8'h10;
  localparam logic [AluOpBus-1:0] EXE_REM_OP    = 8'h11;
  localparam logic [AluOpBus-1:0] EXE_REMU_OP   = 8'h12;
  localparam logic [AluOpBus-1:0] EXE_JAL_OP    = 8'h13;

  typedef enum logic [1:0] {
    DivFree = 2'b00,
    DivOn   = 2'b01,
    DivEnd  = 2'b10
  } div_state_e;

  function automatic logic is_signed_div_op(input logic [AluOpBus-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_REM_OP);
  endfunction

  function automatic logic is_rem_op(input logic [AluOpBus-1:0] op);
    return (op == EXE_REM_OP) || (op == EXE_REMU_OP);
  endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up on the last step, result held in DivEnd until the stage may advance.
module ex_div
  import ex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic              is_rem,
  input  logic [RegBus-1:0] opdata1,
  input  logic [RegBus-1:0] opdata2,
  input  logic              hold,
  output logic [RegBus-1:0] result,
  output logic              busy
);

  div_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [RegBus-1:0] rem_q, rem_d;
  logic [RegBus-1:0] quo_q, quo_d;
  logic [RegBus-1:0] divisor_q, divisor_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic [RegBus-1:0] result_q, result_d;

  logic [RegBus:0]   shifted;
  logic [RegBus:0]   trial;
  logic [RegBus-1:0] abs_dividend;
  logic [RegBus-1:0] abs_divisor;

  assign abs_dividend = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
  assign abs_divisor  = (signed_div && opdata2[31]) ? -opdata2 : opdata2;

  // The partial remainder is always below the divisor, so the 33-bit shifted
  // value minus the divisor borrows into bit 32 exactly when the trial fails.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, divisor_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    result_d  = result_q;

    case (state_q)
      DivFree: begin
        if (start) begin
          is_rem_d  = is_rem;
          neg_quo_d = signed_div && (opdata1[31] ^ opdata2[31]);
          neg_rem_d = signed_div && opdata1[31];
          if (opdata2 == ZeroWord) begin
            result_d = is_rem ? opdata1 : 32'hFFFF_FFFF;
            state_d  = DivEnd;
          end else begin
            rem_d     = ZeroWord;
            quo_d     = abs_dividend;
            divisor_d = abs_divisor;
            cnt_d     = 5'd0;
            state_d   = DivOn;
          end
        end
      end

      DivOn: begin
        if (!trial[RegBus]) begin
          rem_d = trial[RegBus-1:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[RegBus-1:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          if (is_rem_q) begin
            result_d = neg_rem_q ? -rem_d : rem_d;
          end else begin
            result_d = neg_quo_q ? -quo_d : quo_d;
          end
          state_d = DivEnd;
        end
      end

      DivEnd: begin
        // A downstream stall must not let the same instruction restart the divide.
        if (hold == NoStop) begin
          state_d = DivFree;
        end
      end

      default: begin
        state_d = DivFree;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= DivFree;
      cnt_q     <= 5'd0;
      rem_q     <= ZeroWord;
      quo_q     <= ZeroWord;
      divisor_q <= ZeroWord;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      result_q  <= ZeroWord;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      result_q  <= result_d;
    end
  end

  assign result = (state_q == DivEnd) ? result_q : ZeroWord;
  assign busy   = (rst != RstEnable) &&
                  (((state_q == DivFree) && start) || (state_q == DivOn));

endmodule

// File: rtl/ex.sv
// Execute stage of the RV32IM pipeline: combinational ALU, link and multiply
// results plus the iterative divider, selected by the decoded result class.
module ex
  import ex_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AluOpBus-1:0]   aluop_i,
  input  logic [AluSelBus-1:0]  alusel_i,
  input  logic [RegBus-1:0]     reg1_i,
  input  logic [RegBus-1:0]     reg2_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     link_addr_i,
  input  logic [5:0]            stall,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  stallreq
);

  logic [RegBus-1:0] logic_res;
  logic [RegBus-1:0] shift_res;
  logic [RegBus-1:0] arith_res;
  logic [RegBus-1:0] mul_res;
  logic [RegBus-1:0] div_res;
  logic [4:0]        shamt;
  logic [63:0]       mul_op1;
  logic [63:0]       mul_op2;
  logic [63:0]       product;
  logic              div_start;
  logic              div_hold;
  logic              div_busy;
  logic              unused_stall_bits;

  // Only the EX bit of the stall vector matters here.
  assign unused_stall_bits = ^{stall[5:4], stall[2:0]};

  assign shamt = reg2_i[4:0];

  always_comb begin
    logic_res = ZeroWord;
    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      default:    logic_res = ZeroWord;
    endcase
  end

  always_comb begin
    shift_res = ZeroWord;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg1_i << shamt;
      EXE_SRL_OP: shift_res = reg1_i >> shamt;
      EXE_SRA_OP: shift_res = $unsigned($signed(reg1_i) >>> shamt);
      default:    shift_res = ZeroWord;
    endcase
  end

  always_comb begin
    arith_res = ZeroWord;
    case (aluop_i)
      EXE_ADD_OP:  arith_res = reg1_i + reg2_i;
      EXE_SUB_OP:  arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP: arith_res = {31'd0, reg1_i < reg2_i};
      default:     arith_res = ZeroWord;
    endcase
  end

  // Extending each operand to 64 bits by its own signedness lets one
  // truncated 64x64 product serve all four multiply flavours.
  always_comb begin
    mul_op1 = {32'd0, reg1_i};
    mul_op2 = {32'd0, reg2_i};
    if ((aluop_i == EXE_MULH_OP) || (aluop_i == EXE_MULHSU_OP)) begin
      mul_op1 = {{32{reg1_i[31]}}, reg1_i};
    end
    if (aluop_i == EXE_MULH_OP) begin
      mul_op2 = {{32{reg2_i[31]}}, reg2_i};
    end
  end

  assign product = mul_op1 * mul_op2;
  assign mul_res = (aluop_i == EXE_MUL_OP) ? product[31:0] : product[63:32];

  assign div_start = (alusel_i == EXE_RES_DIV);
  assign div_hold  = (stall[3] == Stop);

  ex_div u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .signed_div (is_signed_div_op(aluop_i)),
    .is_rem     (is_rem_op(aluop_i)),
    .opdata1    (reg1_i),
    .opdata2    (reg2_i),
    .hold       (div_hold),
    .result     (div_res),
    .busy       (div_busy)
  );

  always_comb begin
    wd_o     = wd_i;
    wreg_o   = wreg_i;
    stallreq = div_busy;
    case (alusel_i)
      EXE_RES_LOGIC:       wdata_o = logic_res;
      EXE_RES_SHIFT:       wdata_o = shift_res;
      EXE_RES_ARITH:       wdata_o = arith_res;
      EXE_RES_JUMP_BRANCH: wdata_o = link_addr_i;
      EXE_RES_MUL:         wdata_o = mul_res;
      EXE_RES_DIV:         wdata_o = div_res;
      default:             wdata_o = ZeroWord;
    endcase
    if (rst == RstEnable) begin
      wd_o     = NOPRegAddr;
      wreg_o   = 1'b0;
      wdata_o  = ZeroWord;
      stallreq = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the execute stage: ALU/MUL vectors, divide
// latency and results, downstream hold in DivEnd and reset mid-divide.
module tb_ex;
  import ex_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [AluOpBus-1:0]   aluop_i;
  logic [AluSelBus-1:0]  alusel_i;
  logic [RegBus-1:0]     reg1_i;
  logic [RegBus-1:0]     reg2_i;
  logic [RegAddrBus-1:0] wd_i;
  logic                  wreg_i;
  logic [RegBus-1:0]     link_addr_i;
  logic [5:0]            stall;
  logic [RegAddrBus-1:0] wd_o;
  logic                  wreg_o;
  logic [RegBus-1:0]     wdata_o;
  logic                  stallreq;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  ex dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .link_addr_i (link_addr_i),
    .stall       (stall),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stallreq    (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    aluop_i  = EXE_NOP_OP;
    alusel_i = EXE_RES_NOP;
    @(posedge clk); #1;
  endtask

  // Issues one divide at the current cycle, measures how long stallreq stays
  // high, checks the DivEnd result, optionally holds EX with stall[3].
  task automatic run_div(input string name, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_len,
                         input int hold_cycles);
    int len;
    aluop_i  = op;
    alusel_i = EXE_RES_DIV;
    reg1_i   = a;
    reg2_i   = b;
    #1;
    len = 0;
    while (stallreq === 1'b1 && len < 40) begin
      len++;
      @(posedge clk); #2;
    end
    checks++;
    if (len !== exp_len) begin
      failures++;
      $display("FAIL %s stall_len: got %0d expected %0d", name, len, exp_len);
    end
    checks++;
    if (wdata_o !== exp || stallreq !== 1'b0) begin
      failures++;
      $display("FAIL %s result: got %h stallreq=%b expected %h stallreq=0",
               name, wdata_o, stallreq, exp);
    end
    $display("div %s a=%h b=%h result=%h stall_cycles=%0d", name, a, b, wdata_o, len);
    if (hold_cycles > 0) begin
      stall = 6'b001111;
      for (int i = 0; i < hold_cycles; i++) begin
        @(posedge clk); #2;
        checks++;
        if (stallreq !== 1'b0 || wdata_o !== exp) begin
          failures++;
          $display("FAIL %s hold_%0d: got %h stallreq=%b expected %h stallreq=0",
                   name, i, wdata_o, stallreq, exp);
        end
      end
      stall = 6'b000000;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wd_i = 5'h1F; wreg_i = 1'b1;
    aluop_i = EXE_ADD_OP; alusel_i = EXE_RES_ARITH; reg1_i = 32'd1; reg2_i = 32'd1;
    @(posedge clk); @(posedge clk); #2;
    checks++;
    if (wd_o !== 5'd0) begin failures++; $display("FAIL reset_wd: got %h expected 00", wd_o); end
    checks++;
    if (wreg_o !== 1'b0) begin failures++; $display("FAIL reset_wreg: got %b expected 0", wreg_o); end
    checks++;
    if (wdata_o !== 32'd0) begin failures++; $display("FAIL reset_wdata: got %h expected 0", wdata_o); end
    checks++;
    if (stallreq !== 1'b0) begin failures++; $display("FAIL reset_stallreq: got %b expected 0", stallreq); end
    $display("reset wd=%h wreg=%b wdata=%h stallreq=%b", wd_o, wreg_o, wdata_o, stallreq);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
  endtask

  task automatic test_alu();
    alu_vec_t v [18];
    v[0]  = '{EXE_RES_ARITH, EXE_ADD_OP,    32'd5,         32'hFFFF_FFFD, 32'd2};
    v[1]  = '{EXE_RES_SHIFT, EXE_SRA_OP,    32'h8000_0000, 32'd4,         32'hF800_0000};
    v[2]  = '{EXE_RES_ARITH, EXE_SUB_OP,    32'd3,         32'd5,         32'hFFFF_FFFE};
    v[3]  = '{EXE_RES_ARITH, EXE_SLT_OP,    32'hFFFF_FFFF, 32'd1,         32'd1};
    v[4]  = '{EXE_RES_ARITH, EXE_SLTU_OP,   32'hFFFF_FFFF, 32'd1,         32'd0};
    v[5]  = '{EXE_RES_LOGIC, EXE_AND_OP,    32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    v[6]  = '{EXE_RES_LOGIC, EXE_OR_OP,     32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
    v[7]  = '{EXE_RES_LOGIC, EXE_XOR_OP,    32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0};
    v[8]  = '{EXE_RES_SHIFT, EXE_SLL_OP,    32'd1,         32'h0000_0023, 32'd8};
    v[9]  = '{EXE_RES_SHIFT, EXE_SRL_OP,    32'h8000_0000, 32'd4,         32'h0800_0000};
    v[10] = '{EXE_RES_MUL,   EXE_MUL_OP,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE};
    v[11] = '{EXE_RES_MUL,   EXE_MULH_OP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    v[12] = '{EXE_RES_MUL,   EXE_MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    v[13] = '{EXE_RES_MUL,   EXE_MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[14] = '{EXE_RES_JUMP_BRANCH, EXE_JAL_OP, 32'd0,      32'd0,         32'h0000_1004};
    v[15] = '{EXE_RES_NOP,   EXE_NOP_OP,    32'd7,         32'd7,         32'd0};
    v[16] = '{EXE_RES_ARITH, EXE_ADD_OP,    32'h7FFF_FFFF, 32'd1,         32'h8000_0000};
    v[17] = '{EXE_RES_MUL,   EXE_MULHU_OP,  32'hFFFF_FFFF, 32'd2,         32'd1};
    link_addr_i = 32'h0000_1004;
    for (int i = 0; i < 18; i++) begin
      alusel_i = v[i].sel; aluop_i = v[i].op; reg1_i = v[i].a; reg2_i = v[i].b;
      wd_i = 5'(i + 1); wreg_i = i[0];
      #1;
      checks++;
      if (wdata_o !== v[i].exp) begin
        failures++;
        $display("FAIL alu_%0d op=%h wdata: got %h expected %h", i, v[i].op, wdata_o, v[i].exp);
      end
      checks++;
      if (stallreq !== 1'b0) begin
        failures++;
        $display("FAIL alu_%0d stallreq: got %b expected 0", i, stallreq);
      end
      checks++;
      if (wd_o !== 5'(i + 1) || wreg_o !== i[0]) begin
        failures++;
        $display("FAIL alu_%0d passthrough: got wd=%h wreg=%b expected wd=%h wreg=%b",
                 i, wd_o, wreg_o, 5'(i + 1), i[0]);
      end
      $display("alu op=%h a=%h b=%h wdata=%h", v[i].op, v[i].a, v[i].b, wdata_o);
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_back_to_back();
    run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 33, 0);
    run_div("remu_100_7", EXE_REMU_OP, 32'd100, 32'd7, 32'd2, 33, 0);
    run_div("divu_max_1", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0);
    idle();
  endtask

  task automatic test_div_signed();
    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_div("rem_m7_2", EXE_REM_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_div("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
    run_div("rem_ovf", EXE_REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0);
    idle();
  endtask

  task automatic test_div_by_zero();
    run_div("div_9_0", EXE_DIV_OP, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_div("rem_9_0", EXE_REM_OP, 32'd9, 32'd0, 32'd9, 1, 0);
    idle();
  endtask

  task automatic test_div_hold();
    run_div("divu_hold", EXE_DIVU_OP, 32'd1000, 32'd3, 32'd333, 33, 3);
    run_div("divu_after_hold", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 33, 0);
    idle();
  endtask

  task automatic test_reset_mid_div();
    aluop_i = EXE_DIVU_OP; alusel_i = EXE_RES_DIV; reg1_i = 32'd100; reg2_i = 32'd7;
    repeat (11) @(posedge clk);
    #2;
    checks++;
    if (stallreq !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid pre_stallreq: got %b expected 1", stallreq);
    end
    rst = 1'b1; aluop_i = EXE_NOP_OP; alusel_i = EXE_RES_NOP;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (stallreq !== 1'b0 || wdata_o !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid post: got stallreq=%b wdata=%h expected stallreq=0 wdata=0",
               stallreq, wdata_o);
    end
    $display("rst_mid post stallreq=%b wdata=%h", stallreq, wdata_o);
    @(posedge clk); #1;
    run_div("divu_after_rst", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 33, 0);
    idle();
  endtask

  initial begin
    rst = 1'b1; aluop_i = EXE_NOP_OP; alusel_i = EXE_RES_NOP;
    reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
    link_addr_i = '0; stall = 6'b000000;
    test_reset();
    test_alu();
    test_back_to_back();
    test_div_signed();
    test_div_by_zero();
    test_div_hold();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage RV32IM pipeline. It sits between the ID/EX pipeline register and the EX/MEM pipeline register. It computes the result of the decoded operation:
- RV32I ALU ops, link address and single-cycle MUL are combinational.
- DIV/DIVU/REM/REMU run through an iterative radix-2 divider that raises `stallreq` until the result is ready.

## Interface
Parameters: none. Widths come from `define.v`: `RegBus`=32, `RegAddrBus`=5, `AluOpBus`=8, `AluSelBus`=3.
- `clk` in 1: the single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset (`RstEnable`=1'b1).
- `aluop_i` in `AluOpBus`: operation code from ID/EX.
- `alusel_i` in `AluSelBus`: result class from ID/EX.
- `reg1_i` in 32: operand 1. `reg2_i` in 32: operand 2.
- `wd_i` in 5: destination register. `wreg_i` in 1: write enable.
- `link_addr_i` in 32: return address for JAL/JALR.
- `stall` in 6: global stall vector; bit 3 = EX stage.
- `wd_o` out 5: destination register, passed through.
- `wreg_o` out 1: write enable, passed through.
- `wdata_o` out 32: result.
- `stallreq` out 1: stall request to the controller.

## Operation
- Outputs are combinational from the inputs and divider state. During `rst`: `wd_o`=`NOPRegAddr`, `wreg_o`=0, `wdata_o`=`ZeroWord`, `stallreq`=0.
- Result mux by `alusel_i`:
  - `EXE_RES_LOGIC`: AND/OR/XOR.
  - `EXE_RES_SHIFT`: SLL/SRL/SRA, shift amount = `reg2_i[4:0]`.
  - `EXE_RES_ARITH`: ADD/SUB/SLT/SLTU, 32-bit wrap, no overflow trap.
  - `EXE_RES_JUMP_BRANCH`: `link_addr_i`.
  - `EXE_RES_MUL`: MUL/MULH/MULHSU/MULHU from a 64-bit product; low word for MUL, high word otherwise.
  - `EXE_RES_DIV`: divider result.
  - `EXE_RES_NOP`: 0.
- Divider FSM. State is held in the sub-module; `stallreq` is derived from the state.
  - **DivFree**: idle. When `alusel_i`=`EXE_RES_DIV`, latch the operands:
    - signed ops take absolute values;
    - record result sign: quotient negative iff the signs differ; remainder takes the dividend's sign.
    - `stallreq`=1.
    - If the divisor is 0, go to DivEnd. Otherwise clear the partial remainder, load the dividend into the shift register, set the counter to 0 and go to DivOn.
  - **DivOn**: one restoring step per cycle:
    - shift {rem, quo} left by 1;
    - trial-subtract the divisor;
    - if the result is non-negative, commit it and set quo[0]=1;
    - counter++.
    - After the step with counter=31, apply sign correction and go to DivEnd. `stallreq`=1.
  - **DivEnd**: result valid. `stallreq`=0 and `wdata_o` = quotient (DIV/DIVU) or remainder (REM/REMU). Go to DivFree when `stall[3]`=`NoStop`; otherwise hold DivEnd so a downstream stall does not restart the divide.
- Special cases, per the RISC-V spec:
  - divisor 0: quotient = 32'hFFFF_FFFF, remainder = dividend.
  - signed overflow, 32'h8000_0000 / 32'hFFFF_FFFF: quotient = 32'h8000_0000, remainder = 0. This falls out of the magnitude path and needs no special logic beyond the sign fix.
- Reset in any state: go to DivFree, clear the counter and result registers. `stallreq` is 0 in the next cycle.
- `wd_o` and `wreg_o` always follow `wd_i` and `wreg_i`. While stalled, ID/EX holds them stable.

## Timing
- Non-divide ops: 0-cycle combinational; result captured by EX/MEM at the next edge.
- Divide with nonzero divisor, entering at cycle T:
  - `stallreq` high in T..T+32 (DivFree at T, DivOn at T+1..T+32);
  - DivEnd at T+33 with `stallreq` low and a valid result;
  - EX/MEM captures at the end of T+33.
- Divide by zero: `stallreq` high at T only; result at T+1.
- While `stallreq`=1, the controller stalls stages 0-3 and EX/MEM takes a bubble. ID/EX therefore holds the divide instruction until DivEnd.
- Back-to-back divides: the second enters DivFree one cycle after DivEnd exits.

## Structure
- Shared constants in `define.v`:
  - `DivFree`, `DivOn`, `DivEnd` (2 bits);
  - `EXE_RES_MUL`, `EXE_RES_DIV`;
  - aluop codes `EXE_DIV_OP`, `EXE_DIVU_OP`, `EXE_REM_OP`, `EXE_REMU_OP`, `EXE_MUL*_OP`;
  - `Stop`, `NoStop`.
- Sub-module `div`:
  - inputs: `clk`, `rst`, `start`, `signed_div`, `is_rem`, `opdata1`, `opdata2`, `hold`;
  - outputs: `result`, `busy`.
  - It contains the FSM, counter and shift registers. `ex` keeps the combinational ALU and the mux.

## Test plan
- ADD 5+(-3) and SRA 32'h8000_0000>>>4 -> `wdata_o`=2, then 32'hF800_0000, same cycle; `stallreq` stays 0.
- DIVU 100/7 issued at T -> `stallreq` high T..T+32; at T+33 `wdata_o`=14; REMU on the same operands gives 2.
- DIV −7/2 -> −3 (32'hFFFF_FFFD); REM −7/2 -> −1; DIV 32'h8000_0000/−1 -> 32'h8000_0000 and REM -> 0.
- DIV 9/0 -> `stallreq` for 1 cycle, then `wdata_o`=32'hFFFF_FFFF; REM 9/0 -> 9.
- Divide reaches DivEnd while `stall[3]`=Stop for 3 cycles -> stays in DivEnd with `wdata_o` stable, no restart; leaves on release.
- `rst` pulsed at DivOn cycle 10 -> next cycle `stallreq`=0 and `wdata_o`=0. A fresh DIVU 100/7 afterwards completes with the full 33-cycle stall.
